// File: rtl/rnd_pipe.sv
// rnd_pipe: multi-lane two-stage mantissa rounder, modes RNE/RTZ/RNA/SR, valid/ready.
// Define RND_SR_EN to build the LFSR-driven stochastic mode; otherwise mode 11 acts as RNE.
module rnd_pipe #(
  parameter int width_i = 10,
  parameter int width_o = 4,
  parameter int lanes   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [1:0]               i_mode,
  input  logic [lanes*width_i-1:0] i_num,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [lanes*width_o-1:0] o_man,
  output logic [lanes-1:0]         o_ofl
);
  localparam int d = width_i - width_o;

  logic                     v1;
  logic                     v2;
  logic                     rdy1;
  logic                     rdy2;
  logic                     acc;
  logic [lanes*width_i-1:0] num1;
  logic [1:0]               mode1;
  logic [lanes*width_o-1:0] man_n;
  logic [lanes-1:0]         ofl_n;

  if (width_i < width_o + 2) begin : g_chk_w
    $error("rnd_pipe: width_i must be >= width_o + 2");
  end
  if (lanes < 1) begin : g_chk_l
    $error("rnd_pipe: lanes must be >= 1");
  end

  assign rdy2    = !v2 | i_ready;
  assign rdy1    = !v1 | rdy2;
  assign o_ready = rdy1;
  assign acc     = i_valid & rdy1;
  assign o_valid = v2;

`ifdef RND_SR_EN
  logic [15:0] lfsr;
  logic [15:0] snap1;

  if (d > 16) begin : g_chk_d
    $error("rnd_pipe: SR needs width_i - width_o <= 16");
  end

  // Fibonacci x^16+x^14+x^13+x^11+1; value is snapshotted before the step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr  <= 16'hACE1;
      snap1 <= '0;
    end else if (acc) begin
      lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      snap1 <= lfsr;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1    <= 1'b0;
      num1  <= '0;
      mode1 <= '0;
    end else if (rdy1) begin
      v1 <= i_valid;
      if (i_valid) begin
        num1  <= i_num;
        mode1 <= i_mode;
      end
    end
  end

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    logic [width_i-1:0] x;
    logic               g;
    logic               s;
    logic               rne;
    logic               sr;
    logic               inc;

    assign x   = num1[j*width_i +: width_i];
    assign g   = x[d-1];
    assign s   = |x[d-2:0];
    assign rne = g & (s | x[d]);

`ifdef RND_SR_EN
    localparam int sh = (3 * j) % 16;
    logic [31:0] dbl;
    logic [d:0]  sum;

    // upper half of the doubled word is the rotate-left by sh
    assign dbl = {snap1, snap1} << sh;
    assign sum = {1'b0, x[d-1:0]} + {1'b0, dbl[16 +: d]};
    assign sr  = sum[d];
`else
    assign sr = rne;
`endif

    always_comb begin
      inc = 1'b0;
      unique case (1'b1)
        mode1 == 2'b00: inc = rne;
        mode1 == 2'b01: inc = 1'b0;
        mode1 == 2'b10: inc = g;
        mode1 == 2'b11: inc = sr;
        default:        inc = 1'b0;
      endcase
    end

    assign {ofl_n[j], man_n[j*width_o +: width_o]} =
      {1'b0, x[width_i-1:d]} + (width_o + 1)'(inc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2    <= 1'b0;
      o_man <= '0;
      o_ofl <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        o_man <= man_n;
        o_ofl <= ofl_n;
      end
    end
  end

endmodule
